// File: rtl/pixel_point_op.sv
// Per-pixel point operation on the centre pixel of a neighbourhood vector: bypass, invert,
// brightness, threshold or grayscale. It has a 3-stage valid/ready pipeline. Define POINTOP_SATCNT_EN to add sat_count.
module pixel_point_op #(
   parameter int CW = 4,
   parameter int NB = 9
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           mode,
   input  logic signed [CW:0]   offset,
   input  logic [CW-1:0]        thresh,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sof,
   input  logic [NB*3*CW-1:0]   color_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sof,
   output logic [3*CW-1:0]      filter_rgb_out
`ifdef POINTOP_SATCNT_EN
   ,
   output logic [15:0]          sat_count
`endif
);

   localparam int PW = 3*CW;
   localparam int VW = CW+2;
   localparam logic [CW-1:0] MAX = '1;

   typedef logic signed [VW-1:0] wide_t;

   // Values are bounded to (-2^CW, 2^(CW+1)), so bit VW-1 is the sign and bit CW flags > MAX.
   function automatic logic [CW-1:0] sat_chan(input wide_t v);
      if (v[VW-1])
         sat_chan = '0;
      else if (v[CW])
         sat_chan = MAX;
      else
         sat_chan = v[CW-1:0];
   endfunction

   function automatic logic clamped(input wide_t v);
      clamped = v[VW-1] | v[CW];
   endfunction

   logic [2:0]         cfg_mode;
   logic signed [CW:0] cfg_off;
   logic [CW-1:0]      cfg_thr;

   logic               vld_p1, sof_p1;
   logic [PW-1:0]      pix_p1;
   logic [2:0]         mode_p1;
   logic signed [CW:0] off_p1;
   logic [CW-1:0]      thr_p1;

   logic               vld_p2, sof_p2;
   wide_t              val_p2 [3];
   wide_t              val_nx [3];

   logic               vld_p3, sof_p3;
   logic [PW-1:0]      rgb_p3;
   logic [PW-1:0]      rgb_nx;

   logic               ld1, ld2, ld3, in_xfer;
   logic [CW+4:0]      r_ext, g_ext, b_ext, y_sum;
   logic [CW-1:0]      gray, ch;
   wide_t              ch_w, off_w;
   logic               unused_ok;

   assign ld3       = !vld_p3 || out_ready;
   assign ld2       = !vld_p2 || ld3;
   assign ld1       = !vld_p1 || ld2;
   assign in_ready  = ld1;
   assign in_xfer   = in_valid && ld1;
   assign unused_ok = ^{color_data[(NB-1)*PW-1:0], y_sum[3:0], y_sum[CW+4]};

   // S1: capture centre pixel and the config it will be processed with
   always_ff @(posedge clk) begin
      if (in_xfer) begin
         pix_p1  <= color_data[NB*PW-1 -: PW];
         mode_p1 <= in_sof ? mode   : cfg_mode;
         off_p1  <= in_sof ? offset : cfg_off;
         thr_p1  <= in_sof ? thresh : cfg_thr;
      end
      if (ld2 && vld_p1)
         val_p2 <= val_nx;
   end

   // S2: per-channel operation in widened signed arithmetic
   always_comb begin
      r_ext = (CW+5)'(pix_p1[PW-1 -: CW]);
      g_ext = (CW+5)'(pix_p1[2*CW-1 -: CW]);
      b_ext = (CW+5)'(pix_p1[CW-1:0]);
      y_sum = (r_ext << 2) + r_ext + (g_ext << 3) + g_ext + (b_ext << 1);
      gray  = y_sum[CW+3:4];
      off_w = wide_t'(off_p1);
      ch    = '0;
      ch_w  = '0;
      for (int i = 0; i < 3; i++) begin
         ch   = pix_p1[(2-i)*CW +: CW];
         ch_w = wide_t'({2'b00, ch});
         case (mode_p1)
            3'd1:    val_nx[i] = wide_t'({2'b00, MAX - ch});
            3'd2:    val_nx[i] = ch_w + off_w;
            3'd3:    val_nx[i] = (ch >= thr_p1) ? wide_t'({2'b00, MAX}) : '0;
            3'd4:    val_nx[i] = wide_t'({2'b00, gray});
            default: val_nx[i] = ch_w;
         endcase
      end
   end

   // S3: saturate to the channel range and present at the output
   always_comb begin
      rgb_nx = {sat_chan(val_p2[0]), sat_chan(val_p2[1]), sat_chan(val_p2[2])};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_p1   <= 1'b0;
         sof_p1   <= 1'b0;
         vld_p2   <= 1'b0;
         sof_p2   <= 1'b0;
         vld_p3   <= 1'b0;
         sof_p3   <= 1'b0;
         rgb_p3   <= '0;
         cfg_mode <= '0;
         cfg_off  <= '0;
         cfg_thr  <= '0;
      end else begin
         if (ld1) begin
            vld_p1 <= in_valid;
            sof_p1 <= in_valid && in_sof;
         end
         if (ld2) begin
            vld_p2 <= vld_p1;
            sof_p2 <= vld_p1 && sof_p1;
         end
         if (ld3) begin
            vld_p3 <= vld_p2;
            sof_p3 <= vld_p2 && sof_p2;
            if (vld_p2)
               rgb_p3 <= rgb_nx;
         end
         if (in_xfer && in_sof) begin
            cfg_mode <= mode;
            cfg_off  <= offset;
            cfg_thr  <= thresh;
         end
      end
   end

   assign out_valid      = vld_p3;
   assign out_sof        = sof_p3;
   assign filter_rgb_out = rgb_p3;

`ifdef POINTOP_SATCNT_EN
   // Clamp count travels with the pixel; the running total snapshots into sat_count at each SOF
   logic [1:0]  nclamp_nx, nclamp_p3;
   logic [15:0] run_cnt;
   logic [16:0] run_sum;

   assign nclamp_nx = {1'b0, clamped(val_p2[0])} + {1'b0, clamped(val_p2[1])}
                    + {1'b0, clamped(val_p2[2])};
   assign run_sum   = {1'b0, run_cnt} + 17'(nclamp_p3);

   always_ff @(posedge clk) begin
      if (ld3 && vld_p2)
         nclamp_p3 <= nclamp_nx;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         run_cnt   <= '0;
         sat_count <= '0;
      end else if (vld_p3 && out_ready) begin
         if (sof_p3) begin
            sat_count <= run_cnt;
            run_cnt   <= 16'(nclamp_p3);
         end else begin
            run_cnt <= run_sum[16] ? 16'hFFFF : run_sum[15:0];
         end
      end
   end
`endif

endmodule
